// File: rtl/lakespec_cfg_sequencer.sv
// lakespec_cfg_sequencer: assembles a config_memory image from narrow config
// words, commits it atomically, then sequences the flush and run phases of a
// lakespec instance while reporting run progress.
module lakespec_cfg_sequencer #(
    parameter int CONFIG_MEMORY_SIZE = 512,
    parameter int WORD_WIDTH         = 32,
    parameter int FLUSH_CYCLES       = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WORD_WIDTH-1:0]         cfg_word,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          run_cycles,
    output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
    output logic                          flush,
    output logic                          cfg_loaded,
    output logic                          running,
    output logic                          done,
    output logic [63:0]                   cycle_count,
    output logic [2:0]                    dbg_state
);

    localparam int NWORDS = (CONFIG_MEMORY_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int LAST_W = CONFIG_MEMORY_SIZE - (NWORDS - 1) * WORD_WIDTH;
    localparam int FC_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NWORDS - 1);
    localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]                    state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [CONFIG_MEMORY_SIZE-1:0] shadow_q, shadow_d;
    logic [CONFIG_MEMORY_SIZE-1:0] cfg_mem_q, cfg_mem_d;
    logic                          loaded_q, loaded_d;
    logic                          flush_q, flush_d;
    logic                          running_q, running_d;
    logic                          done_q, done_d;
    logic [63:0]                   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]          rem_q, rem_d;
    logic [FC_W-1:0]               fcnt_q, fcnt_d;

    logic                          cfg_accept;
    logic                          start_ok;
    logic [IDX_W-1:0]              widx;

    // Handshake: a word transfers on every rising edge where cfg_valid and
    // cfg_ready are both 1; cfg_ready depends only on state, never on cfg_valid,
    // so the producer may hold cfg_valid and stream one word per cycle.
    assign cfg_ready  = (state_q != S_FLUSH) && (state_q != S_RUN);
    assign cfg_accept = cfg_valid && cfg_ready;
    // A word arriving with start wins, so start needs cfg_valid low.
    assign start_ok   = start && !cfg_valid && ((state_q == S_READY) || (state_q == S_DONE));
    // Outside LOAD every accepted word begins a fresh image at word 0.
    assign widx       = (state_q == S_LOAD) ? idx_q : '0;

    assign config_memory = cfg_mem_q;
    assign flush         = flush_q;
    assign cfg_loaded    = loaded_q;
    assign running       = running_q;
    assign done          = done_q;
    assign cycle_count   = cnt_q;
    assign dbg_state     = state_q;

    // Next-state logic: word loading and commit, then flush/run sequencing.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        cfg_mem_d = cfg_mem_q;
        loaded_d  = loaded_q;
        flush_d   = flush_q;
        running_d = running_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        fcnt_d    = fcnt_q;

        if (cfg_accept) begin
            for (int k = 0; k < NWORDS - 1; k++) begin
                if (widx == IDX_W'(k)) begin
                    shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = cfg_word;
                end
            end
            // The last word may straddle the image end; its excess bits are dropped.
            if (widx == LAST_IDX) begin
                shadow_d[(NWORDS-1)*WORD_WIDTH +: LAST_W] = cfg_word[LAST_W-1:0];
            end
            done_d = 1'b0;
            if (widx == LAST_IDX) begin
                cfg_mem_d = shadow_d;
                loaded_d  = 1'b1;
                idx_d     = '0;
                state_d   = S_READY;
            end else begin
                idx_d   = widx + IDX_W'(1);
                state_d = S_LOAD;
            end
        end else if (start_ok) begin
            rem_d   = run_cycles;
            cnt_d   = '0;
            done_d  = 1'b0;
            flush_d = 1'b1;
            fcnt_d  = '0;
            state_d = S_FLUSH;
        end else if (state_q == S_FLUSH) begin
            if (fcnt_q == FLUSH_LAST) begin
                flush_d = 1'b0;
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    running_d = 1'b1;
                    state_d   = S_RUN;
                end
            end else begin
                fcnt_d = fcnt_q + FC_W'(1);
            end
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + 64'd1;
            rem_d = rem_q - CNT_WIDTH'(1);
            if (rem_q == CNT_WIDTH'(1)) begin
                running_d = 1'b0;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end
        end
    end

    // State registers; reset discards any partial load and the committed image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            cfg_mem_q <= '0;
            loaded_q  <= 1'b0;
            flush_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            cfg_mem_q <= cfg_mem_d;
            loaded_q  <= loaded_d;
            flush_q   <= flush_d;
            running_q <= running_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            fcnt_q    <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_lakespec_cfg_sequencer.sv
// Directed-plus-random bench for lakespec_cfg_sequencer: a 512/32 instance for
// load/run/reset behaviour and a 550/32 instance for the odd-size image.
module tb_lakespec_cfg_sequencer;

    localparam int CMS   = 512;
    localparam int W     = 32;
    localparam int FC    = 4;
    localparam int CW    = 32;
    localparam int NW    = 16;
    localparam int O_CMS = 550;
    localparam int O_NW  = 18;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;

    logic [W-1:0]   cfg_word;
    logic           cfg_valid;
    logic           cfg_ready;
    logic           start;
    logic [CW-1:0]  run_cycles;
    logic [CMS-1:0] config_memory;
    logic           flush, cfg_loaded, running, done;
    logic [63:0]    cycle_count;
    logic [2:0]     dbg_state;

    logic [W-1:0]     o_cfg_word;
    logic             o_cfg_valid;
    logic             o_cfg_ready;
    logic             o_start;
    logic [CW-1:0]    o_run_cycles;
    logic [O_CMS-1:0] o_config_memory;
    logic             o_flush, o_cfg_loaded, o_running, o_done;
    logic [63:0]      o_cycle_count;
    logic [2:0]       o_dbg_state;

    int checks = 0;
    int failures = 0;

    // Reference model: the words of the image being loaded and expected outputs.
    logic [W-1:0] words[$];
    logic [575:0] exp_cfg;
    logic         exp_loaded;
    logic         exp_done;
    logic [63:0]  exp_count;

    lakespec_cfg_sequencer #(
        .CONFIG_MEMORY_SIZE(CMS), .WORD_WIDTH(W), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_word(cfg_word), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .start(start), .run_cycles(run_cycles),
        .config_memory(config_memory), .flush(flush), .cfg_loaded(cfg_loaded),
        .running(running), .done(done), .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    lakespec_cfg_sequencer #(
        .CONFIG_MEMORY_SIZE(O_CMS), .WORD_WIDTH(W), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)
    ) u_odd (
        .clk(clk), .rst_n(rst_n), .cfg_word(o_cfg_word), .cfg_valid(o_cfg_valid),
        .cfg_ready(o_cfg_ready), .start(o_start), .run_cycles(o_run_cycles),
        .config_memory(o_config_memory), .flush(o_flush), .cfg_loaded(o_cfg_loaded),
        .running(o_running), .done(o_done), .cycle_count(o_cycle_count), .dbg_state(o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Image the spec implies: word k at bits [k*W +: W], truncated to size.
    function automatic logic [575:0] image_of(input int size);
        logic [575:0] img;
        img = '0;
        for (int k = 0; k < words.size(); k++) img[k*W +: W] = words[k];
        for (int i = size; i < 576; i++) img[i] = 1'b0;
        return img;
    endfunction

    task automatic model_reset();
        exp_cfg    = '0;
        exp_loaded = 1'b0;
        exp_done   = 1'b0;
        exp_count  = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 1'b1);
        chk({tag, "_cfg_mem"}, config_memory, '0);
        chk({tag, "_flush"}, flush, 1'b0);
        chk({tag, "_loaded"}, cfg_loaded, 1'b0);
        chk({tag, "_running"}, running, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_count"}, cycle_count, '0);
    endtask

    // Send n_send words of a fresh image; fixed selects the 0x1000_0000+k pattern.
    task automatic load(input int n_send, input bit fixed, input bit start_first, input bit gaps);
        words.delete();
        for (int k = 0; k < NW; k++) words.push_back(fixed ? W'(32'h1000_0000 + k) : W'($urandom()));
        for (int k = 0; k < n_send; k++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                cfg_valid = 1'b0;
                start = (k > 0);
                step();
                start = 1'b0;
                chk("gap_no_flush", flush, 1'b0);
                chk("gap_cfg_hold", config_memory, exp_cfg);
            end
            cfg_word  = words[k];
            cfg_valid = 1'b1;
            start     = start_first && (k == 0);
            step();
            start    = 1'b0;
            exp_done = 1'b0;
            if (k == NW - 1) begin
                exp_cfg    = image_of(CMS);
                exp_loaded = 1'b1;
            end
            chk("load_cfg", config_memory, exp_cfg);
            chk("load_loaded", cfg_loaded, exp_loaded);
            chk("load_flush", flush, 1'b0);
            chk("load_done", done, exp_done);
            chk("load_ready", cfg_ready, 1'b1);
        end
        cfg_valid = 1'b0;
        cfg_word  = '0;
    endtask

    // Start a run of rc cycles; abort_at >= 0 asserts reset when the count reaches it.
    task automatic run_seq(input int rc, input int abort_at);
        start = 1'b1;
        run_cycles = CW'(rc);
        step();
        start = 1'b0;
        run_cycles = $urandom();
        exp_count = '0;
        exp_done  = 1'b0;
        for (int i = 0; i < FC; i++) begin
            chk("flush_on", flush, 1'b1);
            chk("flush_not_running", running, 1'b0);
            chk("flush_cfg_ready", cfg_ready, 1'b0);
            chk("flush_cfg_hold", config_memory, exp_cfg);
            chk("flush_done", done, 1'b0);
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_word  = $urandom();
            start     = 1'($urandom_range(0, 1));
            step();
        end
        for (int j = 0; j < rc; j++) begin
            chk("run_on", running, 1'b1);
            chk("run_no_flush", flush, 1'b0);
            chk("run_cfg_ready", cfg_ready, 1'b0);
            chk("run_count", cycle_count, exp_count);
            chk("run_cfg_hold", config_memory, exp_cfg);
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_reset("rst_run");
                cfg_valid = 1'b0;
                start = 1'b0;
                return;
            end
            cfg_valid = 1'($urandom_range(0, 1));
            cfg_word  = $urandom();
            start     = 1'($urandom_range(0, 1));
            step();
            exp_count = exp_count + 64'd1;
        end
        exp_done = 1'b1;
        chk("done_on", done, exp_done);
        chk("done_not_running", running, 1'b0);
        chk("done_no_flush", flush, 1'b0);
        chk("done_count", cycle_count, 64'(rc));
        chk("done_cfg_hold", config_memory, exp_cfg);
        chk("done_cfg_ready", cfg_ready, 1'b1);
        cfg_valid = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        cfg_word = '0; cfg_valid = 1'b0; start = 1'b0; run_cycles = '0;
        o_cfg_word = '0; o_cfg_valid = 1'b0; o_start = 1'b0; o_run_cycles = '0;
        model_reset();

        // Reset values on both instances
        rst_n = 1'b0;
        repeat (3) step();
        chk_reset("reset");
        chk("odd_reset_ready", o_cfg_ready, 1'b1);
        chk("odd_reset_cfg", o_config_memory, '0);
        chk("odd_reset_loaded", o_cfg_loaded, 1'b0);
        chk("odd_reset_flush", o_flush, 1'b0);
        chk("odd_reset_done", o_done, 1'b0);
        chk("odd_reset_count", o_cycle_count, '0);
        rst_n = 1'b1;
        step();

        // start in IDLE is ignored
        start = 1'b1;
        run_cycles = 5;
        step();
        start = 1'b0;
        repeat (3) begin
            chk("idle_start_flush", flush, 1'b0);
            chk("idle_start_running", running, 1'b0);
            chk("idle_start_ready", cfg_ready, 1'b1);
            step();
        end

        // Full fixed-pattern load
        load(NW, 1'b1, 1'b0, 1'b0);
        chk("img_lo", config_memory[31:0], 32'h1000_0000);
        chk("img_hi", config_memory[511:480], 32'h1000_000F);

        // Normal and zero-length runs
        run_seq(100, -1);
        run_seq(0, -1);

        // Random reload with gaps and start pulses during LOAD, random run
        load(NW, 1'b0, 1'b0, 1'b1);
        run_seq(int'($urandom_range(1, 30)), -1);

        // start together with a word in DONE: reload wins
        load(NW, 1'b0, 1'b1, 1'b0);
        run_seq(int'($urandom_range(1, 20)), -1);

        // Restart from DONE with the existing image
        run_seq(int'($urandom_range(1, 10)), -1);

        // Reset after word 7 of a load
        load(8, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset("rst_load");
        step();
        rst_n = 1'b1;
        step();
        load(NW, 1'b0, 1'b0, 1'b1);

        // Reset mid-run at cycle_count 40
        run_seq(100, 40);
        step();
        rst_n = 1'b1;
        step();
        chk_reset("post_rst_run");
        load(NW, 1'b0, 1'b0, 1'b0);
        run_seq(3, -1);

        // Odd size: 550 bits needs 18 words, last word all ones
        words.delete();
        for (int k = 0; k < O_NW - 1; k++) words.push_back($urandom());
        words.push_back(32'hFFFF_FFFF);
        for (int k = 0; k < O_NW; k++) begin
            o_cfg_word  = words[k];
            o_cfg_valid = 1'b1;
            step();
            if (k < O_NW - 1) begin
                chk("odd_load_hold", o_config_memory, '0);
                chk("odd_load_loaded", o_cfg_loaded, 1'b0);
            end else begin
                chk("odd_commit_loaded", o_cfg_loaded, 1'b1);
                chk("odd_commit_img", o_config_memory, image_of(O_CMS));
                chk("odd_top_bits", o_config_memory[549:544], 6'h3F);
            end
        end
        o_cfg_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
